// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer.
// Runs FILL -> WASH -> DRAIN -> FILL -> RINSE -> DRAIN -> SPIN -> DONE, timed in tick_1s pulses,
// and drives registered valve/motor/phase/time_left/status outputs.
module wash_cycle_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WASH_T   = 20,
  parameter int unsigned RINSE_T  = 10,
  parameter int unsigned SPIN_T   = 8,
  parameter int unsigned QWASH_T  = 8,
  parameter int unsigned QRINSE_T = 4,
  parameter int unsigned QSPIN_T  = 4,
  parameter int unsigned DRAIN_T  = 3,
  parameter int unsigned DIR_T    = 2,
  parameter int unsigned FILL_TO  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1s,
  input  logic             start,
  input  logic             abort,
  input  logic             water_full,
  input  logic             mode,
  output logic             valve_in,
  output logic             valve_out,
  output logic             motor_on,
  output logic             motor_dir,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] time_left,
  output logic             done,
  output logic             buzzer_req,
  output logic             err
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFill  = 3'd1,
    StWash  = 3'd2,
    StDrain = 3'd3,
    StRinse = 3'd4,
    StSpin  = 3'd5,
    StDone  = 3'd6,
    StError = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DrainLen  = CNT_W'(DRAIN_T);
  // Counters compare against "last value" so the terminal tick is the one that acts.
  localparam logic [CNT_W-1:0] DirLast   = CNT_W'(DIR_T - 1);
  localparam logic [CNT_W-1:0] FillLast  = CNT_W'(FILL_TO - 1);

  state_e           state_q;
  logic             mode_q;      // mode latched at the accepted start
  logic             rinse_q;     // set once the wash drain completes
  logic [CNT_W-1:0] fill_cnt_q;  // ticks spent in the current fill
  logic [CNT_W-1:0] dir_cnt_q;   // ticks since the last motor reversal
  logic [CNT_W-1:0] wash_len;
  logic [CNT_W-1:0] rinse_len;
  logic [CNT_W-1:0] spin_len;

  assign phase = state_q;

  // Phase lengths selected by the latched mode, never the live input.
  always_comb begin
    wash_len  = mode_q ? CNT_W'(QWASH_T)  : CNT_W'(WASH_T);
    rinse_len = mode_q ? CNT_W'(QRINSE_T) : CNT_W'(RINSE_T);
    spin_len  = mode_q ? CNT_W'(QSPIN_T)  : CNT_W'(SPIN_T);
  end

  // Sequencer: state, timers and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      rinse_q    <= 1'b0;
      fill_cnt_q <= '0;
      dir_cnt_q  <= '0;
      valve_in   <= 1'b0;
      valve_out  <= 1'b0;
      motor_on   <= 1'b0;
      motor_dir  <= 1'b0;
      time_left  <= '0;
      done       <= 1'b0;
      buzzer_req <= 1'b0;
      err        <= 1'b0;
    end else begin
      buzzer_req <= 1'b0;
      if (abort) begin
        state_q    <= StIdle;
        fill_cnt_q <= '0;
        dir_cnt_q  <= '0;
        valve_in   <= 1'b0;
        valve_out  <= 1'b0;
        motor_on   <= 1'b0;
        motor_dir  <= 1'b0;
        time_left  <= '0;
        done       <= 1'b0;
        err        <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (start) begin
              state_q    <= StFill;
              mode_q     <= mode;
              rinse_q    <= 1'b0;
              fill_cnt_q <= '0;
              valve_in   <= 1'b1;
              done       <= 1'b0;
              time_left  <= '0;
            end
          end
          StFill: begin
            // A full drum wins over a coincident timeout tick.
            if (water_full) begin
              state_q   <= rinse_q ? StRinse : StWash;
              time_left <= rinse_q ? rinse_len : wash_len;
              valve_in  <= 1'b0;
              motor_on  <= 1'b1;
              motor_dir <= 1'b0;
              dir_cnt_q <= '0;
            end else if (tick_1s) begin
              if (fill_cnt_q == FillLast) begin
                state_q    <= StError;
                valve_in   <= 1'b0;
                err        <= 1'b1;
                buzzer_req <= 1'b1;
              end else begin
                fill_cnt_q <= fill_cnt_q + CntOne;
              end
            end
          end
          StWash, StRinse: begin
            if (tick_1s) begin
              if (time_left <= CntOne) begin
                state_q   <= StDrain;
                time_left <= DrainLen;
                motor_on  <= 1'b0;
                motor_dir <= 1'b0;
                valve_out <= 1'b1;
              end else begin
                time_left <= time_left - CntOne;
                if (dir_cnt_q == DirLast) begin
                  motor_dir <= ~motor_dir;
                  dir_cnt_q <= '0;
                end else begin
                  dir_cnt_q <= dir_cnt_q + CntOne;
                end
              end
            end
          end
          StDrain: begin
            if (tick_1s && (time_left <= CntOne)) begin
              if (!rinse_q) begin
                state_q    <= StFill;
                rinse_q    <= 1'b1;
                fill_cnt_q <= '0;
                time_left  <= '0;
                valve_out  <= 1'b0;
                valve_in   <= 1'b1;
              end else begin
                state_q   <= StSpin;
                time_left <= spin_len;
                motor_on  <= 1'b1;
                motor_dir <= 1'b0;
              end
            end else if (tick_1s) begin
              time_left <= time_left - CntOne;
            end
          end
          StSpin: begin
            if (tick_1s) begin
              if (time_left <= CntOne) begin
                state_q    <= StDone;
                time_left  <= '0;
                motor_on   <= 1'b0;
                valve_out  <= 1'b0;
                done       <= 1'b1;
                buzzer_req <= 1'b1;
              end else begin
                time_left <= time_left - CntOne;
              end
            end
          end
          StError: begin
            // Only abort or rst leave this state.
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl using short test-sized phase lengths.
module tb_wash_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1s = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       water_full = 1'b0;
  logic       mode = 1'b0;
  logic       valve_in, valve_out, motor_on, motor_dir, done, buzzer_req, err;
  logic [2:0] phase;
  logic [7:0] time_left;

  // Snapshot layout: {phase[2:0], time_left[7:0], vi, vo, mo, md, done, err, buzzer}
  typedef logic [17:0] snap_t;
  typedef struct {
    logic  tk, st, ab, wf, md;
    snap_t exp;
  } step_t;

  // Flag groups {vi, vo, mo, md, done, err, buzzer}
  localparam logic [6:0] Z   = 7'b0000000;
  localparam logic [6:0] FL  = 7'b1000000;
  localparam logic [6:0] WA0 = 7'b0010000;
  localparam logic [6:0] WA1 = 7'b0011000;
  localparam logic [6:0] DR  = 7'b0100000;
  localparam logic [6:0] SP  = 7'b0110000;
  localparam logic [6:0] DN  = 7'b0000100;
  localparam logic [6:0] DNB = 7'b0000101;
  localparam logic [6:0] ER  = 7'b0000010;
  localparam logic [6:0] ERB = 7'b0000011;

  int    tests = 0;
  int    failed = 0;
  snap_t exp_q[$];

  always #5 clk = ~clk;

  wash_cycle_ctrl #(
    .CNT_W(8), .WASH_T(3), .RINSE_T(2), .SPIN_T(2), .QWASH_T(1), .QRINSE_T(1), .QSPIN_T(1),
    .DRAIN_T(1), .DIR_T(1), .FILL_TO(4)
  ) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .start(start), .abort(abort),
    .water_full(water_full), .mode(mode), .valve_in(valve_in), .valve_out(valve_out),
    .motor_on(motor_on), .motor_dir(motor_dir), .phase(phase), .time_left(time_left),
    .done(done), .buzzer_req(buzzer_req), .err(err)
  );

  function automatic snap_t obs();
    return {phase, time_left, valve_in, valve_out, motor_on, motor_dir, done, err, buzzer_req};
  endfunction

  function automatic step_t mk(input logic tk, st, ab, wf, md, input logic [2:0] ph,
                               input logic [7:0] tl, input logic [6:0] fl);
    step_t s;
    s.tk = tk; s.st = st; s.ab = ab; s.wf = wf; s.md = md;
    s.exp = {ph, tl, fl};
    return s;
  endfunction

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic tk, st, ab, wf, md);
    tick_1s = tk; start = st; abort = ab; water_full = wf; mode = md;
    @(posedge clk);
    #1;
    tick_1s = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    snap_t o;
    rst = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      o = obs();
      tests++;
      if (o !== 18'd0) begin
        failed++;
        $display("FAIL reset_hold cyc %0d: got %h want 0", i, o);
      end
    end
    start = 1'b0;
    rst = 1'b0;
    exp_q.push_back({3'd0, 8'd0, Z});
    drive(0, 0, 0, 0, 0);
    o = obs();
    tests++;
    if (o !== exp_q.pop_front()) begin
      failed++;
      $display("FAIL reset_release: got %h want 0", o);
    end
  endtask

  task automatic test_standard();
    step_t s[$];
    snap_t o, e;
    s.push_back(mk(0, 1, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(1, 0, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(1, 0, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(0, 0, 0, 1, 0, 2, 3, WA0));
    s.push_back(mk(0, 0, 0, 0, 0, 2, 3, WA0));
    s.push_back(mk(1, 0, 0, 0, 0, 2, 2, WA1));
    s.push_back(mk(1, 0, 0, 0, 0, 2, 1, WA0));
    s.push_back(mk(1, 0, 0, 0, 0, 3, 1, DR));
    s.push_back(mk(1, 0, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(0, 0, 0, 1, 0, 4, 2, WA0));
    s.push_back(mk(1, 0, 0, 0, 0, 4, 1, WA1));
    s.push_back(mk(1, 0, 0, 0, 0, 3, 1, DR));
    s.push_back(mk(1, 0, 0, 0, 0, 5, 2, SP));
    s.push_back(mk(1, 0, 0, 0, 0, 5, 1, SP));
    s.push_back(mk(1, 0, 0, 0, 0, 6, 0, DNB));
    s.push_back(mk(0, 0, 0, 0, 0, 6, 0, DN));
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].tk, s[i].st, s[i].ab, s[i].wf, s[i].md);
      o = obs();
      e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL standard step %0d: got ph=%0d tl=%0d fl=%b want ph=%0d tl=%0d fl=%b",
                 i, o[17:15], o[14:7], o[6:0], e[17:15], e[14:7], e[6:0]);
      end
    end
  endtask

  task automatic test_fill_timeout();
    step_t s[$];
    snap_t o, e;
    s.push_back(mk(0, 1, 0, 0, 0, 1, 0, FL));  // start straight from DONE
    s.push_back(mk(1, 0, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(1, 0, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(1, 0, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(1, 0, 0, 0, 0, 7, 0, ERB));
    s.push_back(mk(0, 1, 0, 0, 0, 7, 0, ER));
    s.push_back(mk(1, 0, 0, 1, 0, 7, 0, ER));
    s.push_back(mk(0, 0, 1, 0, 0, 0, 0, Z));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, Z));
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].tk, s[i].st, s[i].ab, s[i].wf, s[i].md);
      o = obs();
      e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL fill_timeout step %0d: got ph=%0d tl=%0d fl=%b want ph=%0d tl=%0d fl=%b",
                 i, o[17:15], o[14:7], o[6:0], e[17:15], e[14:7], e[6:0]);
      end
    end
  endtask

  task automatic test_mode_latch();
    step_t s[$];
    snap_t o, e;
    s.push_back(mk(0, 1, 0, 0, 1, 1, 0, FL));
    s.push_back(mk(0, 0, 0, 1, 1, 2, 1, WA0));
    s.push_back(mk(1, 0, 0, 0, 0, 3, 1, DR));  // mode flipped to 0 mid-wash
    s.push_back(mk(1, 0, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(0, 0, 0, 1, 0, 4, 1, WA0));
    s.push_back(mk(1, 0, 0, 0, 0, 3, 1, DR));
    s.push_back(mk(1, 0, 0, 0, 0, 5, 1, SP));
    s.push_back(mk(1, 0, 0, 0, 0, 6, 0, DNB));
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].tk, s[i].st, s[i].ab, s[i].wf, s[i].md);
      o = obs();
      e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL mode_latch step %0d: got ph=%0d tl=%0d fl=%b want ph=%0d tl=%0d fl=%b",
                 i, o[17:15], o[14:7], o[6:0], e[17:15], e[14:7], e[6:0]);
      end
    end
  endtask

  task automatic test_abort_spin();
    step_t s[$];
    snap_t o, e;
    s.push_back(mk(0, 1, 0, 0, 1, 1, 0, FL));
    s.push_back(mk(0, 0, 0, 1, 1, 2, 1, WA0));
    s.push_back(mk(1, 0, 0, 0, 1, 3, 1, DR));
    s.push_back(mk(1, 0, 0, 0, 1, 1, 0, FL));
    s.push_back(mk(0, 0, 0, 1, 1, 4, 1, WA0));
    s.push_back(mk(1, 0, 0, 0, 1, 3, 1, DR));
    s.push_back(mk(1, 0, 0, 0, 1, 5, 1, SP));
    s.push_back(mk(1, 0, 1, 0, 1, 0, 0, Z));   // abort beats the finishing tick
    s.push_back(mk(0, 1, 1, 0, 1, 0, 0, Z));   // held abort ignores start
    s.push_back(mk(0, 0, 0, 0, 1, 0, 0, Z));
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].tk, s[i].st, s[i].ab, s[i].wf, s[i].md);
      o = obs();
      e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL abort_spin step %0d: got ph=%0d tl=%0d fl=%b want ph=%0d tl=%0d fl=%b",
                 i, o[17:15], o[14:7], o[6:0], e[17:15], e[14:7], e[6:0]);
      end
    end
  endtask

  task automatic test_fill_priority();
    step_t s[$];
    snap_t o, e;
    s.push_back(mk(0, 1, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(1, 0, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(1, 0, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(1, 0, 0, 0, 0, 1, 0, FL));
    s.push_back(mk(1, 0, 0, 1, 0, 2, 3, WA0));  // 4th tick with full drum
    s.push_back(mk(0, 1, 0, 0, 1, 2, 3, WA0));
    s.push_back(mk(1, 1, 0, 0, 1, 2, 2, WA1));
    s.push_back(mk(0, 0, 1, 0, 0, 0, 0, Z));
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].tk, s[i].st, s[i].ab, s[i].wf, s[i].md);
      o = obs();
      e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL fill_priority step %0d: got ph=%0d tl=%0d fl=%b want ph=%0d tl=%0d fl=%b",
                 i, o[17:15], o[14:7], o[6:0], e[17:15], e[14:7], e[6:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    snap_t o;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    o = obs();
    tests++;
    if (o !== {3'd2, 8'd3, WA0}) begin
      failed++;
      $display("FAIL async_reset_setup: got %h want %h", o, {3'd2, 8'd3, WA0});
    end
    #2;
    rst = 1'b1;
    #1;
    o = obs();
    tests++;
    if (o !== 18'd0) begin
      failed++;
      $display("FAIL async_reset_immediate: got %h want 0", o);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.push_back({3'd0, 8'd0, Z});
    drive(0, 0, 0, 1, 0);
    o = obs();
    tests++;
    if (o !== exp_q.pop_front()) begin
      failed++;
      $display("FAIL async_reset_after: got %h want 0", o);
    end
  endtask

  initial begin
    test_reset();
    test_standard();
    test_fill_timeout();
    test_mode_latch();
    test_abort_spin();
    test_fill_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
